// File: rtl/cheri_tsmap_painter.sv
// Write-side engine for the temporal-safety revocation bitmap: sets or clears one bit
// per 8-byte heap granule over [base, top), walking the bitmap one 32-bit word at a time.
module cheri_tsmap_painter #(
    parameter logic [31:0] HeapBase  = 32'h2001_0000,
    parameter int unsigned TSMapSize = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_base_i,
    input  logic [31:0] req_top_i,
    input  logic        req_set_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        tsmap_cs_o,
    output logic        tsmap_we_o,
    output logic [15:0] tsmap_addr_o,
    output logic [31:0] tsmap_wdata_o,
    input  logic [31:0] tsmap_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] w_reg, w_next;
    logic [15:0] wl_reg;
    logic [4:0]  lo_reg;
    logic [4:0]  hi_last_reg;
    logic        first_reg, first_next;
    logic        set_reg;
    logic        err_reg;

    // Request decode, evaluated directly on the request inputs at accept time.
    logic [31:0] ob, ot, gs;
    logic [32:0] ge, glast;
    logic [15:0] req_ws, req_wl;
    logic        req_err, req_empty, req_first_full, accept;

    assign ob     = req_base_i - HeapBase;
    assign ot     = req_top_i - HeapBase;
    assign gs     = ob >> 3;
    assign ge     = ({1'b0, ot} + 33'd7) >> 3;
    assign glast  = ge - 33'd1;
    assign req_ws = gs[20:5];
    assign req_wl = glast[20:5];

    // ge == 0 only occurs for an empty range at granule 0; glast would wrap there.
    assign req_err = (req_base_i < HeapBase) || (req_top_i < req_base_i) ||
                     ((ge != 33'd0) && (glast[32:5] >= 28'(TSMapSize)));
    assign req_empty      = (ge == {1'b0, gs});
    assign req_first_full = (gs[4:0] == 5'd0) &&
                            ((req_ws != req_wl) || (glast[4:0] == 5'd31));
    assign accept         = req_valid_i && (state_reg == IDLE);

    // Bit mask for the current word: bits lo..hi inclusive.
    logic [4:0]  lo, hi;
    logic [31:0] mask;
    logic        mask_full;
    logic        next_full;

    assign lo = first_reg ? lo_reg : 5'd0;
    assign hi = (w_reg == wl_reg) ? hi_last_reg : 5'd31;

    for (genvar gi = 0; gi < 32; gi++) begin : g_mask
        assign mask[gi] = (5'(gi) >= lo) && (5'(gi) <= hi);
    end

    assign mask_full = &mask;
    // The following word never has a clipped low end; only the last word can be partial.
    assign next_full = ((w_reg + 16'd1) != wl_reg) || (hi_last_reg == 5'd31);

    always_comb begin
        state_next    = state_reg;
        w_next        = w_reg;
        first_next    = first_reg;
        tsmap_cs_o    = 1'b0;
        tsmap_we_o    = 1'b0;
        tsmap_addr_o  = 16'd0;
        tsmap_wdata_o = 32'd0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    w_next     = req_ws;
                    first_next = 1'b1;
                    if (req_err || req_empty) begin
                        state_next = DONE;
                    end else if (req_first_full) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                tsmap_cs_o   = 1'b1;
                tsmap_addr_o = w_reg;
                state_next   = WR;
            end
            WR: begin
                tsmap_cs_o   = 1'b1;
                tsmap_we_o   = 1'b1;
                tsmap_addr_o = w_reg;
                if (mask_full) begin
                    tsmap_wdata_o = {32{set_reg}};
                end else if (set_reg) begin
                    tsmap_wdata_o = tsmap_rdata_i | mask;
                end else begin
                    tsmap_wdata_o = tsmap_rdata_i & ~mask;
                end
                if (w_reg == wl_reg) begin
                    state_next = DONE;
                end else begin
                    w_next     = w_reg + 16'd1;
                    first_next = 1'b0;
                    state_next = next_full ? WR : RD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            w_reg       <= 16'd0;
            wl_reg      <= 16'd0;
            lo_reg      <= 5'd0;
            hi_last_reg <= 5'd0;
            first_reg   <= 1'b0;
            set_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            first_reg <= first_next;
            if (accept) begin
                wl_reg      <= req_wl;
                lo_reg      <= gs[4:0];
                hi_last_reg <= glast[4:0];
                set_reg     <= req_set_i;
                err_reg     <= req_err;
            end
        end
    end

    assign req_ready_o = (state_reg == IDLE);
    assign busy_o      = (state_reg != IDLE);
    assign done_o      = (state_reg == DONE);
    assign err_o       = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_cheri_tsmap_painter.sv
// Bench for cheri_tsmap_painter: RAM model on the write port, granule-level reference
// model of the bitmap, directed vector table, reset-abort sequence and random requests.
module tb_cheri_tsmap_painter;

    localparam logic [31:0] HB   = 32'h2001_0000;
    localparam int          MAPW = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        set = 1'b0;
    logic [31:0] base = 32'd0;
    logic [31:0] top = 32'd0;
    logic        ready, busy, done, err, cs, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'd0;

    logic [31:0] mem[0:MAPW-1];
    logic [31:0] fill_mem[0:MAPW-1];
    logic        fill_en = 1'b0;
    logic [31:0] ref_map[0:MAPW-1];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } tr_t;

    tr_t exp_q[$];
    bit  m_err;
    int  m_lat;

    typedef struct {
        logic [31:0] b;
        logic [31:0] t;
        logic        s;
        bit          do_fill;
        logic [31:0] pre;
        int          err;
        int          lat;
    } vec_t;

    vec_t tbl[0:11];

    always #5 clk = ~clk;

    cheri_tsmap_painter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (valid),
        .req_ready_o  (ready),
        .req_base_i   (base),
        .req_top_i    (top),
        .req_set_i    (set),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .tsmap_cs_o   (cs),
        .tsmap_we_o   (we),
        .tsmap_addr_o (addr),
        .tsmap_wdata_o(wdata),
        .tsmap_rdata_i(rdata)
    );

    // Synchronous RAM with one-cycle read latency; fill_en reloads the whole array.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < MAPW; i++) mem[i] <= fill_mem[i];
        end else if (cs) begin
            if (we) mem[addr[9:0]] <= wdata;
            else    rdata <= mem[addr[9:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fill(input bit rnd, input logic [31:0] val);
        for (int i = 0; i < MAPW; i++) begin
            fill_mem[i] = rnd ? $urandom : val;
            ref_map[i]  = fill_mem[i];
        end
        @(negedge clk);
        fill_en = 1'b1;
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    task automatic check_reset(input string name);
        chk({name, "_ready"}, ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_cs"}, cs, 0);
        chk({name, "_we"}, we, 0);
        chk({name, "_addr"}, addr, 0);
        chk({name, "_wdata"}, wdata, 0);
    endtask

    // Reference: paint granules one by one, grouping them by bitmap word.
    task automatic model_req(input logic [31:0] b, input logic [31:0] t, input logic s);
        longint unsigned ob, ot, gs, ge, g;
        logic [31:0] mask, nv;
        exp_q.delete();
        m_err = 0;
        if (b < HB || t < b) begin
            m_err = 1;
        end else begin
            ob = longint'(b - HB);
            ot = longint'(t - HB);
            gs = ob / 8;
            ge = (ot + 7) / 8;
            if (ge > 0 && (ge - 1) / 32 >= MAPW) begin
                m_err = 1;
            end else if (ge > gs) begin
                for (longint unsigned w = gs / 32; w <= (ge - 1) / 32; w++) begin
                    mask = 32'd0;
                    for (int k = 0; k < 32; k++) begin
                        g = w * 32 + longint'(k);
                        if (g >= gs && g < ge) mask[k] = 1'b1;
                    end
                    nv = s ? (ref_map[w] | mask) : (ref_map[w] & ~mask);
                    if (mask != 32'hFFFF_FFFF) exp_q.push_back('{1'b0, 16'(w), 32'd0});
                    exp_q.push_back('{1'b1, 16'(w), nv});
                    ref_map[w] = nv;
                end
            end
        end
        m_lat = 1 + exp_q.size();
    endtask

    task automatic run_req(input string name, input logic [31:0] b, input logic [31:0] t,
                           input logic s, input int hand_err, input int hand_lat);
        tr_t obs[$];
        int  cyc, hs_bad, tr_bad, mem_bad, n;
        bit  seen;
        logic got_err;
        model_req(b, t, s);
        @(negedge clk);
        chk({name, "_ready"}, ready, 1);
        valid = 1'b1;
        base  = b;
        top   = t;
        set   = s;
        @(posedge clk);
        cyc = 0; seen = 0; got_err = 0; hs_bad = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            valid = 1'b0;
            cyc++;
            if (cs) obs.push_back('{we, addr, wdata});
            if (ready || !busy) hs_bad++;
            if (err && !done) hs_bad++;
            if (!cs && (addr != 16'd0 || wdata != 32'd0)) hs_bad++;
            if (done) begin
                seen    = 1;
                got_err = err;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_latency"}, cyc, m_lat);
        chk({name, "_err"}, got_err, m_err);
        if (hand_lat >= 0) chk({name, "_latency_table"}, cyc, hand_lat);
        if (hand_err >= 0) chk({name, "_err_table"}, got_err, hand_err);
        chk({name, "_handshake"}, hs_bad, 0);
        chk({name, "_strobes"}, obs.size(), exp_q.size());
        tr_bad = 0;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs[i].we !== exp_q[i].we || obs[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && obs[i].data !== exp_q[i].data)) tr_bad++;
        end
        chk({name, "_trace"}, tr_bad, 0);
        mem_bad = 0;
        for (int i = 0; i < MAPW; i++) if (mem[i] !== ref_map[i]) mem_bad++;
        chk({name, "_bitmap"}, mem_bad, 0);
        $display("req %s base=%h top=%h set=%0d latency=%0d err=%0d strobes=%0d",
                 name, b, t, s, cyc, got_err, obs.size());
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_cnt, cyc, kind;
        logic [31:0] b, t;

        tbl[0]  = '{HB,                32'h2001_0008, 1'b1, 1, 32'h0,         0, 3};
        tbl[1]  = '{HB + 32'h10,       32'h2001_0200, 1'b1, 1, 32'h0,         0, 4};
        tbl[2]  = '{HB + 32'h100,      32'h2001_0101, 1'b0, 1, 32'hFFFF_FFFF, 0, 3};
        tbl[3]  = '{32'h2000_0000,     32'h2001_0008, 1'b1, 1, 32'h0,         1, 1};
        tbl[4]  = '{HB,                32'h2005_0008, 1'b1, 1, 32'h0,         1, 1};
        tbl[5]  = '{HB + 32'h100,      32'h2001_0080, 1'b1, 1, 32'h0,         1, 1};
        tbl[6]  = '{HB + 32'h40,       32'h2001_0040, 1'b1, 1, 32'h0,         0, 1};
        tbl[7]  = '{HB + 32'h8,        32'h2001_0009, 1'b1, 0, 32'h0,         0, 3};
        tbl[8]  = '{HB,                32'h2005_0000, 1'b1, 1, 32'h5A5A_0F0F, 0, 1025};
        tbl[9]  = '{HB + 32'h3FFF8,    32'h2005_0000, 1'b0, 1, 32'hFFFF_FFFF, 0, 3};
        tbl[10] = '{HB + 32'h18,       32'h2001_030C, 1'b1, 1, 32'h0,         0, 7};
        tbl[11] = '{HB,                32'hFFFF_FFFF, 1'b1, 1, 32'h0,         1, 1};

        rst_n = 1'b0;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_fill) fill(0, tbl[i].pre);
            run_req($sformatf("vec%0d", i), tbl[i].b, tbl[i].t, tbl[i].s, tbl[i].err, tbl[i].lat);
        end

        // Reset during the second write of a partial+full two-word request.
        fill(0, 32'h0);
        @(negedge clk);
        valid = 1'b1;
        base  = HB + 32'h10;
        top   = HB + 32'h200;
        set   = 1'b1;
        @(posedge clk);
        wr_cnt = 0;
        cyc    = 0;
        while (wr_cnt < 2 && cyc < 20) begin
            @(negedge clk);
            valid = 1'b0;
            cyc++;
            if (cs && we) wr_cnt++;
        end
        chk("abort_reached_second_write", wr_cnt, 2);
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_word0_kept", mem[0], 32'hFFFF_FFFC);
        chk("abort_word1_untouched", mem[1], 32'h0);
        ref_map[0] = 32'hFFFF_FFFC;
        $display("req abort base=%h top=%h set=1 reset after %0d writes", HB + 32'h10, HB + 32'h200, wr_cnt);
        run_req("after_abort", HB, HB + 32'h8, 1'b1, 0, 3);

        fill(1, 32'h0);
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 9);
            b = HB + $urandom_range(0, 32'h3FFFF);
            t = b + $urandom_range(0, 4096);
            if (kind == 0) b = HB - $urandom_range(1, 256);
            if (kind == 1) t = b - $urandom_range(1, 64);
            if (kind == 2) begin
                b = HB + 32'h40000 - $urandom_range(0, 512);
                t = b + $urandom_range(0, 1024);
            end
            run_req($sformatf("rnd%0d", r), b, t, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
